lcm_from_gcd: RTL and testbench

//  Downstream stage of the GCD unit. Captures the operand pair (a, b) and the GCD result
//  on the rising edge of the GCD unit's done. Computes lcm = (a / gcd) * b sequentially:

---
 rtl/lcm_from_gcd.sv | 151 +++++++++++++++
 tb/tb_lcm_from_gcd.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lcm_from_gcd.sv
// LCM stage fed by the GCD unit: captures (a, b, gcd) on a rising in_valid and
// computes lcm = (a / gcd) * b with a restoring divider followed by a shift-add multiplier.
module lcm_from_gcd #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [WIDTH-1:0]     gcd,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   lcm,
   output logic                 dropped
);

   localparam int unsigned LW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIV    = 2'd1;
   localparam logic [1:0] S_MUL    = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]       r_state,  w_state_nxt;
   logic             r_in_valid_d;
   logic [WIDTH-1:0] r_b,      w_b_nxt;
   logic [WIDTH-1:0] r_gcd,    w_gcd_nxt;
   logic [WIDTH-1:0] r_dvd,    w_dvd_nxt;
   logic [WIDTH-1:0] r_rem,    w_rem_nxt;
   logic [WIDTH-1:0] r_q,      w_q_nxt;
   logic [LW-1:0]    r_mcand,  w_mcand_nxt;
   logic [LW-1:0]    r_acc,    w_acc_nxt;
   logic [CW-1:0]    r_cnt,    w_cnt_nxt;
   logic [LW-1:0]    r_lcm,    w_lcm_nxt;
   logic             r_busy,   r_done,   r_dropped;

   logic             w_cap;
   logic             w_last;
   logic [WIDTH:0]   w_trial;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [LW-1:0]    w_acc_add;

   assign w_cap     = in_valid & ~r_in_valid_d;
   assign w_last    = (r_cnt == CW'(WIDTH - 1));
   // Remainder stays below gcd, so a successful trial subtraction always fits WIDTH bits.
   assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
   assign w_ge      = (w_trial >= {1'b0, r_gcd});
   assign w_diff    = w_trial[WIDTH-1:0] - r_gcd;
   assign w_acc_add = r_acc + (r_q[0] ? r_mcand : LW'(0));

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_b_nxt     = r_b;
      w_gcd_nxt   = r_gcd;
      w_dvd_nxt   = r_dvd;
      w_rem_nxt   = r_rem;
      w_q_nxt     = r_q;
      w_mcand_nxt = r_mcand;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_lcm_nxt   = r_lcm;
      case (r_state)
         S_IDLE: begin
            if (w_cap) begin
               w_dvd_nxt = a;
               w_b_nxt   = b;
               w_gcd_nxt = gcd;
               if ((gcd == '0) || (a == '0) || (b == '0)) begin
                  w_lcm_nxt   = '0;
                  w_state_nxt = S_FINISH;
               end else begin
                  w_rem_nxt   = '0;
                  w_q_nxt     = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_DIV;
               end
            end
         end
         S_DIV: begin
            w_rem_nxt = w_ge ? w_diff : w_trial[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
            w_dvd_nxt = r_dvd << 1;
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_last) begin
               w_cnt_nxt   = '0;
               w_mcand_nxt = LW'(r_b);
               w_acc_nxt   = '0;
               w_state_nxt = S_MUL;
            end
         end
         S_MUL: begin
            w_acc_nxt   = w_acc_add;
            w_q_nxt     = r_q >> 1;
            w_mcand_nxt = r_mcand << 1;
            w_cnt_nxt   = r_cnt + CW'(1);
            if (w_last) begin
               w_cnt_nxt   = '0;
               w_lcm_nxt   = w_acc_add;
               w_state_nxt = S_FINISH;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_in_valid_d <= 1'b0;
         r_b          <= '0;
         r_gcd        <= '0;
         r_dvd        <= '0;
         r_rem        <= '0;
         r_q          <= '0;
         r_mcand      <= '0;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_lcm        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_dropped    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_in_valid_d <= in_valid;
         r_b          <= w_b_nxt;
         r_gcd        <= w_gcd_nxt;
         r_dvd        <= w_dvd_nxt;
         r_rem        <= w_rem_nxt;
         r_q          <= w_q_nxt;
         r_mcand      <= w_mcand_nxt;
         r_acc        <= w_acc_nxt;
         r_cnt        <= w_cnt_nxt;
         r_lcm        <= w_lcm_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_done       <= (w_state_nxt == S_FINISH);
         r_dropped    <= w_cap & (r_state != S_IDLE);
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign lcm     = r_lcm;
   assign dropped = r_dropped;

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Self-checking bench for lcm_from_gcd: vector table, hand-written corner sequences
// and random operands checked against an arithmetic reference model.
module tb_lcm_from_gcd;

   localparam int unsigned W = 16;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic [W-1:0]   a, b, gcd;
   logic           busy, done, dropped;
   logic [2*W-1:0] lcm;

   int n_checks = 0;
   int n_fail   = 0;

   lcm_from_gcd #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .gcd      (gcd),
      .busy     (busy),
      .done     (done),
      .lcm      (lcm),
      .dropped  (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [W-1:0]   g;
      logic [2*W-1:0] exp;
      int             lat;
      int             hold;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic longint euclid(input longint x, input longint y);
      longint p = x, q = y, t;
      while (q != 0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   function automatic longint model_lcm(input longint x, input longint y, input longint g);
      if (x == 0 || y == 0 || g == 0) return 0;
      return (x / g) * y;
   endfunction

   // Called on a negedge; the next posedge sees the rising in_valid.
   task automatic start_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W-1:0] gi);
      a = ai; b = bi; gcd = gi;
      in_valid = 1'b1;
   endtask

   // Follow one operation to its done pulse, optionally injecting a second edge mid-flight.
   task automatic wait_done(input string tag, input longint exp_lcm, input int exp_lat,
                            input int hold, input int glitch_at, input int exp_drop);
      int lat = 0, busy_cnt = 0, drop_cnt = 0, late_busy = 0;
      bit seen = 0;
      while (lat < 100 && !seen) begin
         @(negedge clk);
         lat++;
         if (lat == hold) in_valid = 1'b0;
         if (glitch_at != 0 && lat == glitch_at) begin
            a = 16'd3; b = 16'd5; gcd = 16'd1; in_valid = 1'b1;
         end
         if (glitch_at != 0 && lat == glitch_at + 1) in_valid = 1'b0;
         if (busy) busy_cnt++;
         if (dropped) drop_cnt++;
         if (done) seen = 1;
      end
      chk({tag, " done_seen"}, longint'(seen), 1);
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " lcm"}, longint'(lcm), exp_lcm);
      chk({tag, " busy_cycles"}, busy_cnt, exp_lat);
      chk({tag, " dropped_cnt"}, drop_cnt, exp_drop);
      while (lat < hold) begin
         @(negedge clk);
         lat++;
         if (busy || done) late_busy++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      if (busy || done) late_busy++;
      chk({tag, " no_retrigger_or_extra_done"}, late_busy, 0);
   endtask

   initial begin
      vecs[0] = '{16'd12,    16'd18,    16'd6,  32'd36,         33, 2};
      vecs[1] = '{16'hFFFF,  16'hFFFE,  16'd1,  32'hFFFD0002,   33, 1};
      vecs[2] = '{16'd0,     16'd5,     16'd5,  32'd0,          1,  1};
      vecs[3] = '{16'd0,     16'd0,     16'd0,  32'd0,          1,  1};
      vecs[4] = '{16'd7,     16'd7,     16'd7,  32'd7,          33, 1};
      vecs[5] = '{16'd4,     16'd6,     16'd2,  32'd12,         33, 1};
      vecs[6] = '{16'd5,     16'd0,     16'd5,  32'd0,          1,  3};
      vecs[7] = '{16'd9,     16'd6,     16'd0,  32'd0,          1,  1};
      vecs[8] = '{16'd1,     16'd1,     16'd1,  32'd1,          33, 40};
      vecs[9] = '{16'hFFFF,  16'hFFFF,  16'hFFFF, 32'hFFFF,     33, 1};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; gcd = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", longint'(busy), 0);
      chk("reset done", longint'(done), 0);
      chk("reset dropped", longint'(dropped), 0);
      chk("reset lcm", longint'(lcm), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].g);
         wait_done($sformatf("vec%0d", i), longint'(vecs[i].exp), vecs[i].lat, vecs[i].hold, 0, 0);
      end

      // Second edge arrives mid-operation and must be dropped.
      start_op(16'd12, 16'd18, 16'd6);
      wait_done("drop", 36, 33, 1, 10, 1);

      // Reset mid-operation abandons it; in_valid high at release counts as an edge.
      start_op(16'd100, 16'd75, 16'd25);
      repeat (8) @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset busy", longint'(busy), 0);
      chk("midreset lcm", longint'(lcm), 0);
      chk("midreset done", longint'(done), 0);
      start_op(16'd100, 16'd75, 16'd25);
      @(negedge clk);
      rst_n = 1'b1;
      wait_done("after_reset", 300, 33, 1, 0, 0);

      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] ra, rb, rg, mask;
         mask = W'($urandom_range(0, 3) == 0 ? 16'h00FF : 16'hFFFF);
         ra = W'($urandom) & mask;
         rb = W'($urandom) & mask;
         if (i % 7 == 3) ra = '0;
         rg = W'(euclid(longint'(ra), longint'(rb)));
         start_op(ra, rb, rg);
         wait_done($sformatf("rand%0d a=%0d b=%0d g=%0d", i, ra, rb, rg),
                   model_lcm(longint'(ra), longint'(rb), longint'(rg)),
                   (ra == '0 || rb == '0 || rg == '0) ? 1 : 2 * W + 1,
                   int'($urandom_range(1, 3)), 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
